// File: rtl/eep_i2c_pkg.sv
// Shared constants for the Avalon-attached I2C master: opcodes, register map, FSM states and
// the per-phase bus drive table.
package eep_i2c_pkg;

  localparam logic [2:0] OpStart    = 3'd1;
  localparam logic [2:0] OpStop     = 3'd2;
  localparam logic [2:0] OpWrite    = 3'd3;
  localparam logic [2:0] OpReadAck  = 3'd4;
  localparam logic [2:0] OpReadNack = 3'd5;

  localparam logic [1:0] AddrCmd    = 2'd0;
  localparam logic [1:0] AddrRxData = 2'd1;
  localparam logic [1:0] AddrDiv    = 2'd2;
  localparam logic [1:0] AddrRsvd   = 2'd3;

  typedef enum logic [2:0] {StIdle, StStart, StStop, StBit, StAck} state_e;

  // Returns {scl_oe, sda_oe} for a slot phase; low asks for SDA driven low in bit/ack slots.
  function automatic logic [1:0] bus_drive(state_e st, logic [1:0] ph, logic low);
    logic [1:0] d;
    d = 2'b00;
    case (st)
      StStart:      d = (ph == 2'd3) ? 2'b11 : (ph == 2'd2) ? 2'b01 : 2'b00;
      StStop:       d = (ph == 2'd0) ? 2'b11 : (ph == 2'd3) ? 2'b00 : 2'b01;
      StBit, StAck: d = {(ph == 2'd0) || (ph == 2'd3), low};
      default:      d = 2'b00;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/eep_i2c_tick.sv
// Quarter-period tick generator: pulses every div+1 clocks while enabled, counter held at 0 when
// disabled so every operation starts from a full quarter period.
module eep_i2c_tick (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic [15:0] div,
  output logic        tick
);

  logic [15:0] cnt_q;

  assign tick = en && (cnt_q == div);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (!en || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

endmodule

// File: rtl/eep_i2c_master.sv
// Avalon-MM I2C master issuing START/STOP/WRITE/READ bus primitives one command at a time.
// Define EEP_I2C_IRQ_EN to add the irq output, the irq-enable bit and the done-clear bit.
module eep_i2c_master
  import eep_i2c_pkg::*;
#(
  parameter logic [15:0] DIV_RESET = 16'd249
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        scl_oe,
  output logic        sda_oe,
  input  logic        sda_i
`ifdef EEP_I2C_IRQ_EN
  ,
  output logic        irq
`endif
);

  state_e      state_q, start_state;
  logic [1:0]  phase_q;
  logic [2:0]  bit_cnt_q, op_q, opcode;
  logic [7:0]  shift_q, rxdata_q;
  logic [15:0] div_q, cur_div_q;
  logic        busy_q, done_q, nack_q, tick;
  logic        wr, cmd_wr, accept;

  assign wr     = chipselect && !write_n;
  assign cmd_wr = wr && (address == AddrCmd);
  assign opcode = writedata[2:0];

  always_comb begin
    start_state = StIdle;
    case (opcode)
      OpStart:                           start_state = StStart;
      OpStop:                            start_state = StStop;
      OpWrite, OpReadAck, OpReadNack:    start_state = StBit;
      default:                           start_state = StIdle;
    endcase
  end

  assign accept = cmd_wr && !busy_q && (start_state != StIdle);

  eep_i2c_tick u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (busy_q),
    .div     (cur_div_q),
    .tick    (tick)
  );

`ifdef EEP_I2C_IRQ_EN
  logic irq_en_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en_q <= 1'b0;
    end else if (cmd_wr) begin
      irq_en_q <= writedata[8];
    end
  end

  assign irq = done_q && irq_en_q;

  logic unused_wdata;
  assign unused_wdata = ^{writedata[31:16], writedata[7:3]};
`else
  logic unused_wdata;
  assign unused_wdata = ^{writedata[31:16], writedata[9:8], writedata[7:3]};
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      phase_q   <= 2'd0;
      bit_cnt_q <= 3'd0;
      op_q      <= 3'd0;
      shift_q   <= 8'd0;
      rxdata_q  <= 8'd0;
      div_q     <= DIV_RESET;
      cur_div_q <= DIV_RESET;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      nack_q    <= 1'b0;
      scl_oe    <= 1'b0;
      sda_oe    <= 1'b0;
    end else begin
      if (wr && (address == AddrDiv)) div_q <= writedata[15:0];
`ifdef EEP_I2C_IRQ_EN
      if (cmd_wr && writedata[9]) done_q <= 1'b0;
`endif
      if (accept) begin
        busy_q    <= 1'b1;
        done_q    <= 1'b0;
        cur_div_q <= div_q;
        op_q      <= opcode;
        phase_q   <= 2'd0;
        bit_cnt_q <= 3'd0;
        state_q   <= start_state;
        // Reads shift samples in from the LSB; the tx byte doubles as the shift register.
        shift_q   <= (opcode == OpWrite) ? writedata[15:8] : 8'hFF;
        {scl_oe, sda_oe} <= bus_drive(start_state, 2'd0,
                                      (opcode == OpWrite) && !writedata[15]);
      end else if (tick) begin
        if (phase_q != 2'd3) begin
          phase_q <= phase_q + 2'd1;
          {scl_oe, sda_oe} <= bus_drive(state_q, phase_q + 2'd1, sda_oe);
          if (phase_q == 2'd2 && state_q == StBit) shift_q <= {shift_q[6:0], sda_i};
          if (phase_q == 2'd2 && state_q == StAck && op_q == OpWrite) nack_q <= sda_i;
        end else begin
          phase_q <= 2'd0;
          if (state_q == StBit && bit_cnt_q != 3'd7) begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
            {scl_oe, sda_oe} <= bus_drive(StBit, 2'd0, (op_q == OpWrite) && !shift_q[7]);
          end else if (state_q == StBit) begin
            state_q <= StAck;
            {scl_oe, sda_oe} <= bus_drive(StAck, 2'd0, op_q == OpReadAck);
          end else begin
            if (state_q == StAck && op_q != OpWrite) rxdata_q <= shift_q;
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      AddrCmd: begin
        readdata[2:0] = {done_q, nack_q, busy_q};
`ifdef EEP_I2C_IRQ_EN
        readdata[8] = irq_en_q;
`endif
      end
      AddrRxData: readdata[7:0]  = rxdata_q;
      AddrDiv:    readdata[15:0] = div_q;
      AddrRsvd:   readdata       = '0;
      default:    readdata       = '0;
    endcase
  end

endmodule

// File: tb/tb_eep_i2c_master.sv
// Directed bench for eep_i2c_master with a small open-drain bus monitor and slave model.
module tb_eep_i2c_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        scl_oe, sda_oe;
  logic        scl_line, sda_line, slave_low;

  int checks = 0;
  int errors = 0;

  // Bus monitor state (written only by the monitor process).
  int   fall_cnt = 0, start_cnt = 0, stop_cnt = 0;
  bit   bits[$];
  logic prev_scl = 1'b1, prev_sda = 1'b1;

  // Slave model controls (written only by the stimulus process).
  int         slave_mode = 0;
  int         base_fall = 0;
  logic [7:0] slave_byte = 8'h00;

  always #5 clk = ~clk;

  assign scl_line = !scl_oe;
  assign sda_line = !(sda_oe || slave_low);

  eep_i2c_master dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .scl_oe     (scl_oe),
    .sda_oe     (sda_oe),
    .sda_i      (sda_line)
  );

  // Slave: slot k of an operation is entered after k SCL falls since base_fall.
  always_comb begin
    int rel;
    logic [7:0] sh;
    rel = fall_cnt - base_fall;
    sh = slave_byte << rel;
    slave_low = 1'b0;
    if (slave_mode == 1) slave_low = (rel == 8);
    else if (slave_mode == 2 && rel >= 0 && rel < 8) slave_low = !sh[7];
  end

  always @(negedge clk) begin
    if (prev_scl && !scl_line) fall_cnt++;
    if (!prev_scl && scl_line) bits.push_back(sda_line);
    if (prev_scl && scl_line && prev_sda && !sda_line) start_cnt++;
    if (prev_scl && scl_line && !prev_sda && sda_line) stop_cnt++;
    prev_scl = scl_line;
    prev_sda = sda_line;
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; address = 2'd0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    address = 2'd0;
    #1;
    while (readdata[0] && n < 2000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic get_byte(input int b, output logic [7:0] v);
    v = 8'h00;
    for (int i = 0; i < 8; i++) v = {v[6:0], logic'(bits[b + i])};
  endtask

  task automatic test_reset;
    logic [31:0] d;
    repeat (3) @(negedge clk);
    checks++; if (scl_oe !== 1'b0) begin errors++; $display("FAIL reset_scl got %b want 0", scl_oe); end
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda got %b want 0", sda_oe); end
    rd(2'd0, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_status got %h want 0", d); end
    rd(2'd1, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_rxdata got %h want 0", d); end
    rd(2'd2, d);
    checks++; if (d !== 32'd249) begin errors++; $display("FAIL reset_div got %0d want 249", d); end
    rd(2'd3, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_addr3 got %h want 0", d); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_start;
    int n, s0;
    logic [31:0] d;
    bus_write(2'd2, 32'd3);
    s0 = start_cnt;
    bus_write(2'd0, 32'h0000_0001);
    wait_idle(n);
    checks++; if (n !== 16) begin errors++; $display("FAIL start_busy_len got %0d want 16", n); end
    checks++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL start_cond got %0d want 1", start_cnt - s0); end
    checks++; if ({scl_oe, sda_oe} !== 2'b11) begin errors++; $display("FAIL start_end_bus got %b want 11", {scl_oe, sda_oe}); end
    rd(2'd0, d);
    checks++; if (d !== 32'd4) begin errors++; $display("FAIL start_status got %h want 4", d); end
  endtask

  task automatic test_write;
    int n, b;
    logic [7:0] v;
    logic [31:0] d;
    bus_write(2'd2, 32'd1);
    // Acked write of 0xA0.
    slave_mode = 1; base_fall = fall_cnt; b = bits.size();
    bus_write(2'd0, 32'h0000_A003);
    wait_idle(n);
    checks++; if (bits.size() - b !== 9) begin errors++; $display("FAIL wr_a0_nbits got %0d want 9", bits.size() - b); end
    get_byte(b, v);
    checks++; if (v !== 8'hA0) begin errors++; $display("FAIL wr_a0_byte got %h want a0", v); end
    checks++; if (bits[b + 8] !== 1'b0) begin errors++; $display("FAIL wr_a0_ack got %b want 0", bits[b + 8]); end
    rd(2'd0, d);
    checks++; if (d !== 32'd4) begin errors++; $display("FAIL wr_a0_status got %h want 4", d); end
    // Unacked write of 0x3C latches nack.
    slave_mode = 0; b = bits.size();
    bus_write(2'd0, 32'h0000_3C03);
    wait_idle(n);
    get_byte(b, v);
    checks++; if (v !== 8'h3C) begin errors++; $display("FAIL wr_3c_byte got %h want 3c", v); end
    checks++; if (bits[b + 8] !== 1'b1) begin errors++; $display("FAIL wr_3c_ack got %b want 1", bits[b + 8]); end
    rd(2'd0, d);
    checks++; if (d !== 32'd6) begin errors++; $display("FAIL wr_3c_status got %h want 6", d); end
    checks++; if (scl_oe !== 1'b1) begin errors++; $display("FAIL wr_scl_held got %b want 1", scl_oe); end
  endtask

  task automatic test_read_nack;
    int n, b;
    logic [31:0] d;
    slave_mode = 2; slave_byte = 8'h5C; base_fall = fall_cnt; b = bits.size();
    bus_write(2'd0, 32'h0000_0005);
    wait_idle(n);
    slave_mode = 0;
    rd(2'd1, d);
    checks++; if (d !== 32'h5C) begin errors++; $display("FAIL rd_rxdata got %h want 5c", d); end
    checks++; if (bits[b + 8] !== 1'b1) begin errors++; $display("FAIL rd_nack_slot got %b want 1", bits[b + 8]); end
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL rd_sda_end got %b want 0", sda_oe); end
    rd(2'd0, d);
    checks++; if (d !== 32'd6) begin errors++; $display("FAIL rd_status got %h want 6", d); end
  endtask

  task automatic test_busy_drop;
    int n, b, p0, s0;
    logic [7:0] v;
    logic [31:0] d;
    slave_mode = 1; base_fall = fall_cnt; b = bits.size(); p0 = stop_cnt; s0 = start_cnt;
    bus_write(2'd0, 32'h0000_5503);
    bus_write(2'd0, 32'h0000_0002);
    wait_idle(n);
    slave_mode = 0;
    get_byte(b, v);
    checks++; if (v !== 8'h55) begin errors++; $display("FAIL drop_byte got %h want 55", v); end
    checks++; if (stop_cnt - p0 !== 0) begin errors++; $display("FAIL drop_stop got %0d want 0", stop_cnt - p0); end
    checks++; if (start_cnt - s0 !== 0) begin errors++; $display("FAIL drop_start got %0d want 0", start_cnt - s0); end
    rd(2'd0, d);
    checks++; if (d !== 32'd4) begin errors++; $display("FAIL drop_status got %h want 4", d); end
    checks++; if (scl_oe !== 1'b1) begin errors++; $display("FAIL drop_scl got %b want 1", scl_oe); end
  endtask

  task automatic test_reset_mid_read;
    logic [31:0] d;
    slave_mode = 2; slave_byte = 8'h00; base_fall = fall_cnt;
    bus_write(2'd0, 32'h0000_0004);
    repeat (20) @(negedge clk);
    rd(2'd0, d);
    checks++; if (d[0] !== 1'b1) begin errors++; $display("FAIL mid_busy got %b want 1", d[0]); end
    reset_n = 1'b0;
    #1;
    checks++; if (scl_oe !== 1'b0) begin errors++; $display("FAIL mid_rst_scl got %b want 0", scl_oe); end
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL mid_rst_sda got %b want 0", sda_oe); end
    rd(2'd0, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL mid_rst_status got %h want 0", d); end
    rd(2'd2, d);
    checks++; if (d !== 32'd249) begin errors++; $display("FAIL mid_rst_div got %0d want 249", d); end
    slave_mode = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    rd(2'd0, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL mid_no_done got %h want 0", d); end
  endtask

  task automatic test_back_to_back;
    int n, b, s0, p0;
    logic [7:0] v;
    bus_write(2'd2, 32'd0);
    s0 = start_cnt; p0 = stop_cnt;
    bus_write(2'd0, 32'h0000_0001);
    wait_idle(n);
    checks++; if (n !== 4) begin errors++; $display("FAIL b2b_start_len got %0d want 4", n); end
    slave_mode = 1; base_fall = fall_cnt; b = bits.size();
    bus_write(2'd0, 32'h0000_C303);
    wait_idle(n);
    slave_mode = 0;
    checks++; if (n !== 36) begin errors++; $display("FAIL b2b_write_len got %0d want 36", n); end
    get_byte(b, v);
    checks++; if (v !== 8'hC3) begin errors++; $display("FAIL b2b_byte got %h want c3", v); end
    bus_write(2'd0, 32'h0000_0002);
    wait_idle(n);
    checks++; if (n !== 4) begin errors++; $display("FAIL b2b_stop_len got %0d want 4", n); end
    @(negedge clk);
    checks++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL b2b_starts got %0d want 1", start_cnt - s0); end
    checks++; if (stop_cnt - p0 !== 1) begin errors++; $display("FAIL b2b_stops got %0d want 1", stop_cnt - p0); end
    checks++; if ({scl_oe, sda_oe} !== 2'b00) begin errors++; $display("FAIL b2b_end_bus got %b want 00", {scl_oe, sda_oe}); end
  endtask

  initial begin
    test_reset;
    test_start;
    test_write;
    test_read_nack;
    test_busy_drop;
    test_reset_mid_read;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eep_i2c_master.md
EEP_I2C_MASTER -- requirements
Module: eep_i2c_master

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-002 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port address, input, 2 bits: Avalon slave register select.
REQ-004 SHALL have port chipselect, input, 1 bit: Avalon slave select.
REQ-005 SHALL have port write_n, input, 1 bit: Avalon write strobe, active-low.
REQ-006 SHALL have port writedata, input, 32 bits: Avalon write data.
REQ-007 SHALL have port readdata, output, 32 bits: combinational read mux, zero-extended.
REQ-008 SHALL have port scl_oe, output, 1 bit: 1 drives SCL low; 0 releases it.
REQ-009 SHALL have port sda_oe, output, 1 bit: 1 drives SDA low; 0 releases it.
REQ-010 SHALL have port sda_i, input, 1 bit: sampled SDA line, already synchronised externally.
REQ-011 SHALL have parameter DIV_RESET, default 16'd249, giving the reset value of the quarter-period divider.

Function
REQ-012 SHALL decode registers as follows: address 0 write = CMD (bits[2:0] opcode, bits[15:8] tx byte); address 0 read = STATUS (bit0 busy, bit1 nack, bit2 done); address 1 read = RXDATA[7:0]; address 2 read/write = DIV[15:0]; address 3 reads 0.
REQ-013 SHALL use opcodes 1=START, 2=STOP, 3=WRITE, 4=READ_ACK, 5=READ_NACK; any other opcode is ignored.
REQ-014 SHALL accept a CMD write only when busy=0; a CMD write while busy SHALL be dropped with no state change.
REQ-015 SHALL set busy on the clock edge after an accepted CMD write, and clear done on that same edge.
REQ-016 SHALL generate a quarter tick every DIV+1 clocks from a counter that is held at 0 while idle; DIV=0 SHALL give a tick every clock.
REQ-017 SHALL sample DIV only at command acceptance; a DIV write during busy SHALL take effect on the next command.
REQ-018 SHALL implement FSM states IDLE, START, STOP, BIT, ACK, each bit slot lasting 4 quarter ticks (phases 0 to 3).
REQ-019 SHALL run START as: SDA released with SCL released (ph0-1), then SDA low (ph2), then SCL low (ph3), then return to IDLE.
REQ-020 SHALL run STOP as: SDA low with SCL low (ph0), then SCL released (ph1-2), then SDA released (ph3), then return to IDLE.
REQ-021 SHALL drive SDA in BIT during phase 0 with SCL low (MSB first), release SCL in phases 1-2, sample sda_i at the end of phase 2, and drive SCL low in phase 3.
REQ-022 SHALL, for WRITE, run 8 BIT slots driving the tx byte, then one ACK slot with SDA released; the sampled value SHALL be latched into nack.
REQ-023 SHALL, for READ_*, release SDA for 8 slots, shift the samples into RXDATA, then drive the ACK slot low for READ_ACK and released for READ_NACK; nack SHALL be left unchanged.
REQ-024 SHALL, on completion, clear busy, set done and enter IDLE on the same edge; SCL SHALL remain low after every operation except STOP.

Reset
REQ-025 SHALL, on reset_n=0, immediately force: FSM=IDLE, scl_oe=0, sda_oe=0, busy=0, nack=0, done=0, RXDATA=0, DIV=DIV_RESET, tick counter=0.
REQ-026 SHALL abort any in-flight operation on reset with no completion reported; the bus SHALL be released within the reset cycle.

Configuration
REQ-027 SHALL, with EEP_I2C_IRQ_EN defined, add output irq, 1 bit, equal to done AND STATUS bit8 (irq enable, R/W, reset 0); a write to address 0 with bit9=1 SHALL clear done.
REQ-028 SHALL, without EEP_I2C_IRQ_EN, omit the irq port and bits 8 and 9, which SHALL read 0.

Structure
REQ-029 SHALL place the opcode constants, the FSM state enum and the register address constants in package eep_i2c_pkg.
REQ-030 SHALL implement the quarter-tick divider as sub-module eep_i2c_tick (inputs clk, reset_n, en, div; output tick).

Verification
REQ-031 SHALL cover: DIV=3, START -> SDA falls while SCL is released, then SCL falls; busy lasts 16 clocks (+1 edge); done=1.
REQ-032 SHALL cover: WRITE 0xA0 with the ACK slot held low -> SDA pattern 1,0,1,0,0,0,0,0 at SCL rising edges; nack=0.
REQ-033 SHALL cover: READ_NACK with the model driving 0x5C -> RXDATA=0x5C; master releases SDA in the 9th slot.
REQ-034 SHALL cover: a CMD STOP write during a busy WRITE -> ignored; the WRITE completes unchanged and no STOP is seen.
REQ-035 SHALL cover: reset_n pulsed low mid-READ -> scl_oe=0, sda_oe=0, busy=0, DIV=249 immediately.
REQ-036 SHALL cover: DIV=0, a full START/WRITE/STOP sequence -> back-to-back operation passes with no tick skipped.
